// File: rtl/axis_debug_pkg.sv
// Shared types for the axis_debug response fabric.
package axis_debug_pkg;

   localparam int AXIS_DEBUG_DATA_W = 8;

   typedef enum logic {
      IDLE,
      PASS
   } arb_state_t;

   // One stream beat as it travels through the fabric buffers.
   typedef struct packed {
      logic                         tlast;
      logic [AXIS_DEBUG_DATA_W-1:0] tdata;
   } axis_beat_t;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry output buffer; the pop side is driven straight from the head
// register and push_ready depends only on registered fill.
module axis_skid_buffer #(
   parameter int WIDTH = 9
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_valid,
   output logic             push_ready,
   input  logic [WIDTH-1:0] push_data,
   output logic             pop_valid,
   input  logic             pop_ready,
   output logic [WIDTH-1:0] pop_data
);

   logic [1:0]       count;
   logic [WIDTH-1:0] head;
   logic [WIDTH-1:0] tail;
   logic             push;
   logic             pop;

   assign push_ready = (count != 2'd2);
   assign pop_valid  = (count != 2'd0);
   assign pop_data   = head;
   assign push       = push_valid & push_ready;
   assign pop        = pop_valid & pop_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= 2'd0;
         head  <= '0;
         tail  <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count == 2'd0) head <= push_data;
               else               tail <= push_data;
               count <= count + 2'd1;
            end
            2'b01: begin
               head  <= tail;
               count <= count - 2'd1;
            end
            // Push+pop only happens with one entry held (full blocks push).
            2'b11: begin
               head <= (count == 2'd1) ? push_data : tail;
               tail <= push_data;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/axis_debug_resp_arbiter.sv
// Packet-granular round-robin merge of debug device response streams into
// one registered byte stream toward the host link.
module axis_debug_resp_arbiter
   import axis_debug_pkg::*;
#(
   parameter  int NUM_PORTS = 4,
   localparam int GRANT_W   = $clog2(NUM_PORTS)
) (
   input  logic                                      i_clk,
   input  logic                                      i_rst_n,
   input  logic [NUM_PORTS-1:0]                      i_s_axis_tvalid,
   output logic [NUM_PORTS-1:0]                      o_s_axis_tready,
   input  logic [NUM_PORTS-1:0][AXIS_DEBUG_DATA_W-1:0] i_s_axis_tdata,
   input  logic [NUM_PORTS-1:0]                      i_s_axis_tlast,
   output logic                                      o_m_axis_tvalid,
   input  logic                                      i_m_axis_tready,
   output logic [AXIS_DEBUG_DATA_W-1:0]              o_m_axis_tdata,
   output logic                                      o_m_axis_tlast,
   output logic                                      o_busy,
   output logic [GRANT_W-1:0]                        o_grant
);

   arb_state_t         state, state_nxt;
   logic [GRANT_W-1:0] grant, grant_nxt;
   logic [GRANT_W-1:0] last_grant, last_grant_nxt;
   logic               push_valid;
   logic               buf_ready;
   axis_beat_t         beat_in;
   axis_beat_t         beat_out;

   // First requester scanning upward from the port after the last winner.
   function automatic logic [GRANT_W-1:0] rr_select(
      input logic [NUM_PORTS-1:0] req,
      input logic [GRANT_W-1:0]   last
   );
      logic [GRANT_W-1:0] sel;
      logic               found;
      int                 idx;
      sel   = '0;
      found = 1'b0;
      for (int i = 1; i <= NUM_PORTS; i++) begin
         idx = (int'(last) + i) % NUM_PORTS;
         if (!found && req[idx]) begin
            sel   = GRANT_W'(idx);
            found = 1'b1;
         end
      end
      return sel;
   endfunction

   assign beat_in.tdata = i_s_axis_tdata[grant];
   assign beat_in.tlast = i_s_axis_tlast[grant];

   always_comb begin
      state_nxt       = state;
      grant_nxt       = grant;
      last_grant_nxt  = last_grant;
      o_s_axis_tready = '0;
      push_valid      = 1'b0;
      case (state)
         IDLE: begin
            if (|i_s_axis_tvalid) begin
               grant_nxt = rr_select(i_s_axis_tvalid, last_grant);
               state_nxt = PASS;
            end
         end
         PASS: begin
            o_s_axis_tready[grant] = buf_ready;
            push_valid             = i_s_axis_tvalid[grant];
            if (push_valid && buf_ready && beat_in.tlast) begin
               last_grant_nxt = grant;
               state_nxt      = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= IDLE;
         grant      <= '0;
         last_grant <= GRANT_W'(NUM_PORTS - 1);
      end else begin
         state      <= state_nxt;
         grant      <= grant_nxt;
         last_grant <= last_grant_nxt;
      end
   end

   axis_skid_buffer #(
      .WIDTH($bits(axis_beat_t))
   ) u_skid (
      .clk        (i_clk),
      .rst_n      (i_rst_n),
      .push_valid (push_valid),
      .push_ready (buf_ready),
      .push_data  (beat_in),
      .pop_valid  (o_m_axis_tvalid),
      .pop_ready  (i_m_axis_tready),
      .pop_data   (beat_out)
   );

   assign o_m_axis_tdata = beat_out.tdata;
   assign o_m_axis_tlast = beat_out.tlast;
   assign o_busy         = (state == PASS);
   assign o_grant        = grant;

endmodule
